// File: rtl/instr_encoder8_pkg.sv
// instr_encoder8_pkg: op codes, RV32I opcode/funct constants and FSM states
package instr_encoder8_pkg;
    typedef enum logic [2:0] {
        OP_ADDI = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_BEQ  = 3'd5,
        OP_LUI  = 3'd6,
        OP_ILL  = 3'd7
    } op_e;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;
    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_e;
endpackage

// File: rtl/instr_encoder8_if.sv
// instr_encoder8_if: request side and byte-stream side of the encoder
interface instr_encoder8_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [19:0] imm;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic        err;
    logic [7:0]  instr_count;
    modport slave (
        input  in_valid, op, rd, rs1, rs2, imm, byte_ready,
        output in_ready, byte_out, byte_valid, byte_last, err, instr_count
    );
    modport master (
        output in_valid, op, rd, rs1, rs2, imm, byte_ready,
        input  in_ready, byte_out, byte_valid, byte_last, err, instr_count
    );
endinterface

// File: rtl/instr_encoder8_pack.sv
// rv_field_pack: combinational packing of request fields into an RV32I word
module rv_field_pack
    import instr_encoder8_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [19:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);
    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADDI: word_o = {imm_i[11:0], rs1_i, F3_ADD, rd_i, OPC_OPIMM};
            OP_ADD:  word_o = {F7_BASE, rs2_i, rs1_i, F3_ADD, rd_i, OPC_OP};
            OP_SUB:  word_o = {F7_SUB, rs2_i, rs1_i, F3_ADD, rd_i, OPC_OP};
            OP_AND:  word_o = {F7_BASE, rs2_i, rs1_i, F3_AND, rd_i, OPC_OP};
            OP_OR:   word_o = {F7_BASE, rs2_i, rs1_i, F3_OR, rd_i, OPC_OP};
            OP_BEQ:  word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_ADD,
                               imm_i[4:1], imm_i[11], OPC_BRANCH};
            OP_LUI:  word_o = {imm_i, rd_i, OPC_LUI};
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encoder8.sv
// instr_encoder8: accepts an instruction request, packs it into a 32-bit word
// and streams it out as four bytes with a valid/ready handshake.
module instr_encoder8
    import instr_encoder8_pkg::*;
#(
    parameter bit BYTE_LE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_encoder8_if.slave    bus_if
);
    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] pack_word;
    logic        illegal;
    logic        accept;
    logic        hs;
    logic [1:0]  sel;

    rv_field_pack u_pack (
        .op_i      (bus_if.op),
        .rd_i      (bus_if.rd),
        .rs1_i     (bus_if.rs1),
        .rs2_i     (bus_if.rs2),
        .imm_i     (bus_if.imm),
        .word_o    (pack_word),
        .illegal_o (illegal)
    );

    assign bus_if.in_ready    = (state_q == S_IDLE);
    assign bus_if.byte_valid  = (state_q == S_SEND);
    assign bus_if.byte_last   = bus_if.byte_valid & (idx_q == 2'd3);
    assign bus_if.err         = err_q;
    assign bus_if.instr_count = cnt_q;
    assign accept = bus_if.in_valid & bus_if.in_ready;
    assign hs     = bus_if.byte_valid & bus_if.byte_ready;
    // big-endian order walks the word from the top byte down
    assign sel    = BYTE_LE ? idx_q : ~idx_q;
    assign bus_if.byte_out = word_q[{sel, 3'b000} +: 8];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        err_d   = accept & illegal;
        if (accept && !illegal) begin
            state_d = S_SEND;
            idx_d   = 2'd0;
            word_d  = pack_word;
        end
        if (hs) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                state_d = S_IDLE;
                cnt_d   = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            word_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: doc/instr_encoder8.md
INSTR_ENCODER8 -- requirements
Module: instr_encoder8

Interface
REQ-001 Parameter: BYTE_LE, default 1, byte order of serialized word (1 = bits[7:0] first, 0 = bits[31:24] first).
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request fields valid.
REQ-005 in_ready  output  1  encoder can accept a request.
REQ-006 op  input  3  000 ADDI, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 BEQ, 110 LUI, 111 illegal.
REQ-007 rd / rs1 / rs2  input  5 each  register indices.
REQ-008 imm  input  20  immediate; ADDI uses [11:0], BEQ uses [12:1] as byte offset, LUI uses [19:0].
REQ-009 byte_out  output  8  serialized instruction byte.
REQ-010 byte_valid  output  1  byte_out valid.
REQ-011 byte_ready  input  1  sink accepts byte_out.
REQ-012 byte_last  output  1  high with the 4th byte of a word.
REQ-013 err  output  1  one-cycle pulse on illegal op accepted.
REQ-014 instr_count  output  8  count of words fully transmitted, wraps 255 -> 0.

Function
REQ-015 FSM states IDLE, SEND; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept occurs on a cycle with in_valid & in_ready; all fields registered at that edge.
REQ-017 ADDI word = imm[11:0], rs1, 000, rd, 0010011 (I-type); rs2 ignored.
REQ-018 ADD / SUB / AND / OR word = funct7, rs2, rs1, funct3, rd, 0110011 with (funct7,funct3) = (0000000,000) / (0100000,000) / (0000000,111) / (0000000,110).
REQ-019 BEQ word = imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011; imm[0] and imm[19:13] ignored; rd ignored.
REQ-020 LUI word = imm[19:0], rd, 0110111; rs1, rs2 ignored.
REQ-021 Legal accept: transition IDLE -> SEND; byte_valid SHALL rise the cycle after accept (latency 1) with byte index 0.
REQ-022 In SEND, byte index advances 0..3 only on byte_valid & byte_ready; byte_out, byte_last held stable while byte_ready low.
REQ-023 byte_last = 1 exactly when index = 3.
REQ-024 Handshake on index 3: return to IDLE, byte_valid low and in_ready high next cycle, instr_count increments by 1 (mod 256).
REQ-025 Minimum spacing: 5 cycles from one accept to next (1 load + 4 bytes, byte_ready held high).
REQ-026 Illegal accept (op 111): err = 1 for the next cycle only, state stays IDLE, no byte emitted, instr_count unchanged.
REQ-027 byte_valid SHALL never drop before its handshake except by reset.

Reset
REQ-028 On rst_n low at a clock edge: state IDLE, byte index 0, byte_valid 0, byte_last 0, byte_out 0x00, err 0, instr_count 0x00, in_ready 1 after release.
REQ-029 Reset mid-SEND discards the pending word; no further bytes of it emitted and instr_count not incremented.
REQ-030 in_valid during reset is ignored (no accept).

Structure
REQ-031 Shared package holds op codes (3-bit), RV opcodes (OPC_OPIMM 0010011, OPC_OP 0110011, OPC_BRANCH 1100011, OPC_LUI 0110111), funct3/funct7 constants, FSM state encoding.
REQ-032 Word packing is one combinational sub-module rv_field_pack (op, rd, rs1, rs2, imm -> word[31:0], illegal); encoder owns FSM, word register, byte mux, counter.

Verification (BYTE_LE = 1 unless noted)
REQ-033 ADDI rd=1 rs1=0 imm=5 -> word 0x00500093, bytes 93, 00, 50, 00, last on 4th, instr_count 1.
REQ-034 SUB rd=3 rs1=1 rs2=2 -> 0x402081B3, bytes B3, 81, 20, 40; with BYTE_LE=0 bytes 40, 20, 81, B3.
REQ-035 BEQ rs1=1 rs2=2 imm=8 -> 0x00208463; LUI rd=5 imm=0x12345 -> 0x123452B7.
REQ-036 byte_ready low 3 cycles during byte 1 of ADD rd=1 rs1=2 rs2=3 (0x003100B3) -> byte_out holds 0x00 stable, in_ready stays 0, sequence resumes B3, 00, 31, 00.
REQ-037 op=111 with in_valid -> err pulse exactly 1 cycle, byte_valid stays 0, in_ready stays 1, instr_count unchanged.
REQ-038 rst_n low after byte 2 accepted -> byte_valid 0 next cycle, instr_count 0, next request encodes correctly from byte 0; 256 back-to-back words -> instr_count wraps to 0.
